// File: rtl/uart_pkg.sv
// Shared types, constants and the round-robin priority helper for the UART arbiter.
package uart_pkg;

    localparam int unsigned UART_FRAME_BITS  = 10;
    localparam int unsigned DEFAULT_BAUD_DIV = 217;
    localparam int unsigned MAX_REQ          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    // First valid requester strictly after ptr, wrapping modulo n; returns ptr if none valid.
    function automatic logic [2:0] rr_next(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (!found && (k <= n) && valid[3'(idx)]) begin
                win   = 3'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the shared serial line and arbiter status.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_tx;
    logic                 busy;
    logic [GW-1:0]        grant_id;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, uart_tx, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, uart_tx, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 frame shifter: one start bit, eight data bits LSB first, one stop bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int unsigned BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned LAST_BIT = UART_FRAME_BITS - 1;

    logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [3:0]                 bit_q, bit_d;
    logic                       active_q, active_d;
    logic                       bit_end_c;

    // Bit timing and shifting; the line always shows shift_q[0], all ones when idle.
    always_comb begin
        shift_d   = shift_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        active_d  = active_q;
        bit_end_c = active_q && (baud_q == BAUD_W'(BAUD_DIV - 1));
        done      = bit_end_c && (bit_q == 4'(LAST_BIT));
        if (load) begin
            shift_d  = {1'b1, data, 1'b0};
            baud_d   = '0;
            bit_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (bit_end_c) begin
                baud_d  = '0;
                shift_d = {1'b1, shift_q[UART_FRAME_BITS-1:1]};
                if (bit_q == 4'(LAST_BIT)) begin
                    bit_d    = '0;
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                baud_d = baud_q + BAUD_W'(1);
            end
        end
    end

    // State registers; reset aborts any frame and returns the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            active_q <= active_d;
        end
    end

    assign tx = shift_q[0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART transmit line among requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BAUD_DIV     = DEFAULT_BAUD_DIV,
    parameter int unsigned HOLD_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    arb_state_e         state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      rr_q, rr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] ready_c;
    logic               load_c;
    logic [GW-1:0]      winner_c;
    logic [GW-1:0]      sel_c;
    logic [7:0]         byte_c;
    logic               ser_done_c;
    logic               ser_tx;

    // Next owner when the line is free, searched from the requester after the last owner.
    always_comb begin
        winner_c = GW'(rr_next(8'(bus.req_valid), 3'(rr_q), NUM_REQ));
    end

    // Byte presented to the serializer: the rr winner when idle, the lock holder otherwise.
    always_comb begin
        sel_c  = (state_q == ST_HOLD) ? grant_q : winner_c;
        byte_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_c == GW'(i)) begin
                byte_c = bus.req_data[8*i +: 8];
            end
        end
    end

    // Arbiter FSM: next state, ready strobes and serializer load.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        last_d  = last_q;
        ready_c = '0;
        load_c  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        ready_c[winner_c] = 1'b1;
                        load_c            = 1'b1;
                        grant_d           = winner_c;
                        rr_d              = winner_c;
                        last_d            = bus.req_last[winner_c];
                        state_d           = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ser_done_c) begin
                        if (last_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLD;
                            timer_d = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    ready_c[grant_q] = 1'b1;
                    if (bus.req_valid[grant_q]) begin
                        load_c  = 1'b1;
                        last_d  = bus.req_last[grant_q];
                        state_d = ST_SEND;
                    end else if (timer_q == TW'(HOLD_TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM, owner, rr pointer and hold timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= GW'(NUM_REQ - 1);
            timer_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            last_q  <= last_d;
        end
    end

    uart_tx_serializer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .data (byte_c),
        .tx   (ser_tx),
        .done (ser_done_c)
    );

    assign bus.req_ready = ready_c;
    assign bus.uart_tx   = ser_tx;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed sequences, grant-order table and random streams.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned B  = 4;
    localparam int unsigned HT = 16;
    localparam int unsigned FRAME = 10 * B;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } item_t;

    typedef struct {
        logic            do_rst;
        logic [3:0]      mask;
        int              n;
        logic [3:0][1:0] ord;
        logic [7:0]      base;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BAUD_DIV     (B),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    item_t pend_q   [N][$];
    item_t stream_q [N][$];
    logic  cur_v [N];
    logic [7:0] cur_d [N];
    logic  cur_l [N];
    int    cur_gap [N];
    int    gap_cnt [N];
    logic [N-1:0] hs_q = '0;

    logic mon_en      = 1'b1;
    logic strict_hold = 1'b0;
    int   open_owner  = -1;
    int   n_dec       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic item_t mk(input logic [7:0] d, input logic l, input int g);
        item_t it;
        it.data = d;
        it.last = l;
        it.gap  = g;
        return it;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) hs_q <= bus.req_valid & bus.req_ready;

    // Requester drivers: present queued bytes, hold until accepted, then honour the gap.
    initial begin
        item_t it;
        for (int i = 0; i < N; i++) begin
            cur_v[i] = 1'b0; cur_d[i] = '0; cur_l[i] = 1'b0; cur_gap[i] = 0; gap_cnt[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (cur_v[i]) begin
                    if (hs_q[i]) begin
                        cur_v[i]   = 1'b0;
                        gap_cnt[i] = cur_gap[i];
                    end
                end else if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                end else if (pend_q[i].size() > 0) begin
                    it         = pend_q[i].pop_front();
                    cur_v[i]   = 1'b1;
                    cur_d[i]   = it.data;
                    cur_l[i]   = it.last;
                    cur_gap[i] = it.gap;
                    stream_q[i].push_back(it);
                end
            end
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i]       = cur_v[i];
                bus.req_data[8*i +: 8] = cur_d[i];
                bus.req_last[i]        = cur_l[i];
            end
        end
    end

    // Line monitor: decode each frame and compare with the owner's expected stream.
    initial begin
        logic [7:0] b;
        item_t e;
        int id;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (bus.busy === 1'b0) begin
                if (strict_hold && open_owner >= 0) begin
                    n_checks++;
                    $display("FAIL early_release: grant dropped mid-message of req %0d (cycle %0d)", open_owner, cyc);
                end
                open_owner = -1;
            end
            if (bus.uart_tx === 1'b0) begin
                repeat (B / 2) @(negedge clk);
                chk("mon_start_bit", 32'(bus.uart_tx), 32'd0);
                for (int k = 0; k < 8; k++) begin
                    repeat (B) @(negedge clk);
                    b[k] = bus.uart_tx;
                end
                repeat (B) @(negedge clk);
                chk("mon_stop_bit", 32'(bus.uart_tx), 32'd1);
                id = int'(bus.grant_id);
                n_dec++;
                if (open_owner >= 0) chk("mon_no_interleave", 32'(id), 32'(open_owner));
                if (stream_q[id].size() == 0) begin
                    n_checks++;
                    $display("FAIL mon_unexpected_byte: got %0h from req %0d, expected none", b, id);
                end else begin
                    e = stream_q[id].pop_front();
                    chk("mon_byte", 32'(b), 32'(e.data));
                    open_owner = e.last ? -1 : id;
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_hs(input int budget, output logic [N-1:0] hs);
        hs = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            if (hs != '0) return;
        end
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        logic empty;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int i = 0; i < N; i++)
                if (pend_q[i].size() != 0 || cur_v[i] || gap_cnt[i] != 0) empty = 1'b0;
            if (empty && bus.busy === 1'b0 && bus.uart_tx === 1'b1) ok = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("idle_reached", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        logic [N-1:0] hs;
        logic [9:0]   fr;
        int           h1, h2;
        logic         r0_seen;
        int           total;
        int           len;
        int           who;

        vecs[0] = '{do_rst: 1'b1, mask: 4'b0110, n: 2, ord: {2'd0, 2'd0, 2'd2, 2'd1}, base: 8'h30};
        vecs[1] = '{do_rst: 1'b0, mask: 4'b0011, n: 2, ord: {2'd0, 2'd0, 2'd1, 2'd0}, base: 8'h40};
        vecs[2] = '{do_rst: 1'b0, mask: 4'b1001, n: 2, ord: {2'd0, 2'd0, 2'd0, 2'd3}, base: 8'h50};
        vecs[3] = '{do_rst: 1'b0, mask: 4'b1111, n: 4, ord: {2'd0, 2'd3, 2'd2, 2'd1}, base: 8'h60};
        vecs[4] = '{do_rst: 1'b0, mask: 4'b0001, n: 1, ord: {2'd0, 2'd0, 2'd0, 2'd0}, base: 8'h70};
        vecs[5] = '{do_rst: 1'b0, mask: 4'b1100, n: 2, ord: {2'd0, 2'd0, 2'd3, 2'd2}, base: 8'h80};
        vecs[6] = '{do_rst: 1'b0, mask: 4'b1010, n: 2, ord: {2'd0, 2'd0, 2'd3, 2'd1}, base: 8'h90};
        vecs[7] = '{do_rst: 1'b0, mask: 4'b0100, n: 1, ord: {2'd0, 2'd0, 2'd0, 2'd2}, base: 8'hA0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_uart_tx", 32'(bus.uart_tx), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);

        // Single byte 0x41: exact line waveform and one-cycle ready pulse.
        pend_q[0].push_back(mk(8'h41, 1'b1, 0));
        wait_hs(20, hs);
        chk("t1_handshake", 32'(hs), 32'b0001);
        fr = {1'b1, 8'h41, 1'b0};
        for (int j = 1; j <= int'(FRAME); j++) begin
            @(negedge clk);
            chk("t1_line_bit", 32'(bus.uart_tx), 32'(fr[(j - 1) / int'(B)]));
            if (j == 1) begin
                chk("t1_ready_pulse", 32'(bus.req_ready), 32'd0);
                chk("t1_busy", 32'(bus.busy), 32'd1);
            end
        end
        @(negedge clk);
        chk("t1_idle_line", 32'(bus.uart_tx), 32'd1);
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);
        wait_idle(50);

        // Grant-order table: all masked requesters send one byte; losers stay valid.
        for (int r = 0; r < 8; r++) begin
            if (vecs[r].do_rst) do_reset();
            for (int i = 0; i < N; i++)
                if (vecs[r].mask[i]) pend_q[i].push_back(mk(vecs[r].base + 8'(i), 1'b1, 0));
            for (int k = 0; k < vecs[r].n; k++) begin
                wait_hs(200, hs);
                chk("tbl_winner", 32'(hs), 32'(4'b0001 << vecs[r].ord[k]));
                @(negedge clk);
                chk("tbl_grant_id", 32'(bus.grant_id), 32'(vecs[r].ord[k]));
            end
            wait_idle(200);
        end

        // Locked two-byte message from req3 while req0 waits.
        pend_q[3].push_back(mk(8'h0D, 1'b0, 0));
        pend_q[3].push_back(mk(8'h0A, 1'b1, 0));
        pend_q[0].push_back(mk(8'h55, 1'b1, 0));
        wait_hs(20, hs);
        chk("t3_first_owner", 32'(hs), 32'b1000);
        h1 = cyc;
        r0_seen = 1'b0;
        hs = '0;
        for (int n = 0; n < 200 && hs == '0; n++) begin
            @(negedge clk);
            if (bus.req_ready[0]) r0_seen = 1'b1;
            hs = bus.req_valid & bus.req_ready;
        end
        h2 = cyc;
        chk("t3_second_owner", 32'(hs), 32'b1000);
        chk("t3_ready0_low", 32'(r0_seen), 32'd0);
        chk("t3_hold_spacing", 32'(h2 - h1), 32'(FRAME + 1));
        chk("t3_gap_line_high", 32'(bus.uart_tx), 32'd1);
        @(negedge clk);
        chk("t3_next_start", 32'(bus.uart_tx), 32'd0);
        wait_hs(200, hs);
        chk("t3_req0_after", 32'(hs), 32'b0001);
        wait_idle(200);

        // Hold timeout: req2 leaves a message open, req1 waits for the release.
        pend_q[2].push_back(mk(8'hE7, 1'b0, 0));
        wait_hs(20, hs);
        chk("t4_owner", 32'(hs), 32'b0100);
        pend_q[1].push_back(mk(8'h31, 1'b1, 0));
        repeat (FRAME) @(negedge clk);
        r0_seen = 1'b0;
        for (int k = 1; k <= int'(HT); k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.req_ready[1] !== 1'b0) r0_seen = 1'b1;
        end
        chk("t4_hold_busy_window", 32'(r0_seen), 32'd0);
        @(negedge clk);
        chk("t4_released_busy", 32'(bus.busy), 32'd0);
        chk("t4_req1_ready", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        chk("t4_req1_grant", 32'(bus.grant_id), 32'd1);
        wait_idle(200);

        // Reset in the middle of bit 4 aborts the frame.
        mon_en = 1'b0;
        pend_q[0].push_back(mk(8'h5A, 1'b1, 0));
        wait_hs(20, hs);
        chk("t5_owner", 32'(hs), 32'b0001);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_line_high", 32'(bus.uart_tx), 32'd1);
        chk("t5_busy_low", 32'(bus.busy), 32'd0);
        chk("t5_ready_low", 32'(bus.req_ready), 32'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) stream_q[i].delete();
        mon_en = 1'b1;
        pend_q[0].push_back(mk(8'hC3, 1'b1, 0));
        wait_hs(20, hs);
        chk("t5_after_reset_owner", 32'(hs), 32'b0001);
        wait_idle(200);
        chk("t5_stream_drained", 32'(stream_q[0].size()), 32'd0);

        // Random multi-byte messages on all requesters.
        strict_hold = 1'b1;
        n_dec = 0;
        total = 0;
        while (total < 1000) begin
            who = int'($urandom_range(0, N - 1));
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++)
                pend_q[who].push_back(mk(8'($urandom), (k == len - 1), int'($urandom_range(0, 3))));
            total += len;
        end
        wait_idle(total * 80);
        chk("rnd_bytes_decoded", 32'(n_dec), 32'(total));
        for (int i = 0; i < N; i++) chk("rnd_stream_empty", 32'(stream_q[i].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
